// File: rtl/ham_decoder_stream.sv
// Streaming Hamming(7,4) decoder with single-bit correction.
// Two-stage valid/ready pipeline: S1 holds codeword + syndrome, S2 holds the
// corrected nibble, error flag and syndrome. Saturating delivery statistics.
module ham_decoder_stream #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_err,
  output logic [2:0]       out_syn,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Stage 1: raw codeword and its syndrome
  logic       s1_valid_q;
  logic [6:0] s1_code_q;
  logic [2:0] s1_syn_q;

  // Stage 2: corrected result as presented downstream
  logic       s2_valid_q;
  logic [3:0] s2_data_q;
  logic       s2_err_q;
  logic [2:0] s2_syn_q;

  logic [CNT_W-1:0] corr_cnt_q;
  logic [CNT_W-1:0] word_cnt_q;

  logic       s2_can_load;
  logic       out_hs;
  logic [2:0] syn_d;
  logic [6:0] flip_mask;
  logic [6:0] corr_code;

  assign s2_can_load = !s2_valid_q || out_ready;
  // in_ready deliberately ignores in_valid to avoid a combinational loop upstream
  assign in_ready    = !s1_valid_q || s2_can_load;
  assign out_hs      = s2_valid_q && out_ready;

  // Syndrome of the incoming codeword; each bit checks positions with that index bit set
  always_comb begin
    syn_d    = '0;
    syn_d[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
    syn_d[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
    syn_d[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];
  end

  // Invert the bit named by the syndrome; zero syndrome passes the word unchanged
  always_comb begin
    flip_mask = '0;
    if (s1_syn_q != 3'd0) begin
      flip_mask = 7'd1 << (s1_syn_q - 3'd1);
    end
    corr_code = s1_code_q ^ flip_mask;
  end

  // Stage 1 register: loads whenever it is empty or draining into stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= in_code;
        s1_syn_q  <= syn_d;
      end
    end
  end

  // Stage 2 register: holds steady while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
      s2_syn_q   <= '0;
    end else if (s2_can_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= {corr_code[6], corr_code[5], corr_code[4], corr_code[2]};
        s2_err_q  <= (s1_syn_q != 3'd0);
        s2_syn_q  <= s1_syn_q;
      end
    end
  end

  // Saturating statistics; clear takes priority over a same-cycle handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_q <= '0;
      word_cnt_q <= '0;
    end else if (clr_cnt) begin
      corr_cnt_q <= '0;
      word_cnt_q <= '0;
    end else if (out_hs) begin
      if (word_cnt_q != CntMax) begin
        word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
      if (s2_err_q && (corr_cnt_q != CntMax)) begin
        corr_cnt_q <= corr_cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;
  assign out_syn   = s2_syn_q;
  assign corr_cnt  = corr_cnt_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_ham_decoder_stream.sv
// Scoreboard bench for ham_decoder_stream. Two instances (8-bit and 4-bit
// counters) share all inputs; expectations come from the known nibble and
// the flipped position, not from any decoding logic.
module tb_ham_decoder_stream;

  typedef struct packed {
    logic [3:0] data;
    logic       err;
    logic [2:0] syn;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [6:0] in_code;
  logic       out_ready;
  logic       clr_cnt;

  logic       in_ready8, out_valid8, out_err8;
  logic [3:0] out_data8;
  logic [2:0] out_syn8;
  logic [7:0] corr8, word8;

  logic       in_ready4, out_valid4, out_err4;
  logic [3:0] out_data4;
  logic [2:0] out_syn4;
  logic [3:0] corr4, word4;

  ham_decoder_stream #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_code(in_code),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .out_err(out_err8),
    .out_syn(out_syn8), .clr_cnt(clr_cnt), .corr_cnt(corr8), .word_cnt(word8)
  );

  ham_decoder_stream #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_code(in_code),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_err(out_err4),
    .out_syn(out_syn4), .clr_cnt(clr_cnt), .corr_cnt(corr4), .word_cnt(word4)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  int   m_word8 = 0, m_corr8 = 0, m_word4 = 0, m_corr4 = 0;
  bit   done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Codeword positions 1..7; data at 3,5,6,7; parity bit p covers positions j with (j & p) != 0
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [7:0] w;
    int dpos[4];
    dpos = '{3, 5, 6, 7};
    w = '0;
    for (int i = 0; i < 4; i++) w[dpos[i]] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      for (int j = 3; j <= 7; j++) begin
        if ((j & p) != 0 && j != 4) w[p] = w[p] ^ w[j];
      end
    end
    return w[7:1];
  endfunction

  // Present one word (nibble with optional flip at position pos) and wait for acceptance
  task automatic send(input logic [3:0] nib, input int pos);
    logic [6:0] code;
    exp_t e;
    int n;
    code = encode(nib);
    if (pos != 0) code[pos-1] = ~code[pos-1];
    e.data = nib;
    e.err  = (pos != 0);
    e.syn  = 3'(pos);
    in_valid = 1'b1;
    in_code  = code;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready8) begin
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
      n++;
      if (n > 400) begin
        chk("accept_timeout", 1, 0);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
  endtask

  // Monitor: peeks the queue head whenever output is valid, pops on handshake
  initial begin
    exp_t e;
    bit prev_rst;
    prev_rst = 1'b1;
    @(negedge clk);
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_out_valid4", out_valid4, 0);
        chk("rst_in_ready", in_ready8, 1);
        chk("rst_in_ready4", in_ready4, 1);
        chk("rst_out_data", out_data8, 0);
        chk("rst_out_err", out_err8, 0);
        chk("rst_out_syn", out_syn8, 0);
      end
      chk("word_cnt8", word8, m_word8);
      chk("corr_cnt8", corr8, m_corr8);
      chk("word_cnt4", word4, m_word4);
      chk("corr_cnt4", corr4, m_corr4);
      if (rst) begin
        q.delete();
        m_word8 = 0; m_corr8 = 0; m_word4 = 0; m_corr4 = 0;
      end else begin
        if (out_valid8) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = q[0];
            chk("out_data8", out_data8, e.data);
            chk("out_err8", out_err8, e.err);
            chk("out_syn8", out_syn8, e.syn);
            chk("out_valid4", out_valid4, 1);
            chk("out_data4", out_data4, e.data);
            chk("out_err4", out_err4, e.err);
            chk("out_syn4", out_syn4, e.syn);
            if (out_ready) begin
              void'(q.pop_front());
              if (m_word8 < 255) m_word8++;
              if (m_word4 < 15) m_word4++;
              if (e.err && m_corr8 < 255) m_corr8++;
              if (e.err && m_corr4 < 15) m_corr4++;
            end
          end
        end
        if (clr_cnt) begin
          m_word8 = 0; m_corr8 = 0; m_word4 = 0; m_corr4 = 0;
        end
      end
      prev_rst = rst;
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Clean word, then a word with position 5 flipped
    send(4'b1011, 0);
    drain();
    chk("clean_word_cnt", word8, 1);
    chk("clean_corr_cnt", corr8, 0);
    send(4'b1011, 5);
    drain();
    chk("err_word_cnt", word8, 2);
    chk("err_corr_cnt", corr8, 1);
    clr_pulse();

    // All nibbles, clean and with every single-bit flip, back-to-back
    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 8; p++) send(4'(d), p);
    end
    drain();
    chk("exh_word_cnt", word8, 128);
    chk("exh_corr_cnt", corr8, 112);
    chk("exh_word_cnt4", word4, 15);
    chk("exh_corr_cnt4", corr4, 15);
    clr_pulse();

    // Backpressure: two words fill the pipe, the third is refused until drained
    out_ready = 1'b0;
    send(4'h3, 0);
    send(4'hA, 2);
    in_valid = 1'b1;
    in_code  = encode(4'h6);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready8, 0);
      chk("bp_out_valid", out_valid8, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4'h6, 7);
    drain();
    chk("bp_word_cnt", word8, 3);
    chk("bp_corr_cnt", corr8, 2);

    // Random stream with random consumer stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(4'($urandom), int'($urandom_range(0, 7)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Saturation of the 4-bit counters
    clr_pulse();
    for (int i = 0; i < 20; i++) send(4'($urandom), int'($urandom_range(1, 7)));
    drain();
    chk("sat_word4", word4, 15);
    chk("sat_corr4", corr4, 15);
    chk("sat_word8", word8, 20);
    chk("sat_corr8", corr8, 20);

    // Clear coinciding with a handshake: clear wins
    out_ready = 1'b0;
    send(4'h9, 4);
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("clr_hs_valid", out_valid8, 1);
    clr_cnt   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_hs_word8", word8, 0);
    chk("clr_hs_corr8", corr8, 0);
    chk("clr_hs_word4", word4, 0);
    chk("clr_hs_corr4", corr4, 0);
    drain();

    // Mid-stream reset with both stages full
    send(4'h5, 1);
    drain();
    out_ready = 1'b0;
    send(4'hC, 0);
    send(4'h2, 6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid8, 0);
    chk("mid_rst_in_ready", in_ready8, 1);
    chk("mid_rst_word8", word8, 0);
    chk("mid_rst_corr8", corr8, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_no_stale", out_valid8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
